// File: rtl/ps2_mouse_host_ctrl.sv
// Host-side PS/2 mouse sequencer: runs the reset/enable init handshake, then assembles
// 3-byte stream packets into button/dx/dy words.
module ps2_mouse_host_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [10:0] rx_frame,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_done,
    input  logic        tx_err,
    output logic        pkt_valid,
    output logic [2:0]  pkt_btn,
    output logic [8:0]  pkt_dx,
    output logic [8:0]  pkt_dy,
    output logic [1:0]  pkt_ovf,
    output logic        ready,
    output logic        fail
);

    localparam int unsigned RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    typedef enum logic [3:0] {
        StIdle, StSendRst, StWaitAck1, StWaitBat, StWaitId,
        StSendEn, StWaitAck2, StStream, StFail
    } state_e;

    state_e              state_q, state_d, wait_next;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         timer_q, timer_d;
    logic [7:0]          byte0_q, byte0_d, byte1_q, byte1_d;
    logic [7:0]          tx_byte_q, tx_byte_d, exp_byte, rx_byte;
    logic                tx_start_q, tx_start_d, pkt_valid_q, pkt_valid_d;
    logic [2:0]          pkt_btn_q, pkt_btn_d;
    logic [8:0]          pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
    logic [1:0]          pkt_ovf_q, pkt_ovf_d;
    logic                frame_ok, rx_good, rx_bad, expire, enter, init_fail;

    // Data bits arrive LSB first, so bit i sits at frame position 9-i.
    always_comb begin
        rx_byte = '0;
        for (int i = 0; i < 8; i++) rx_byte[i] = rx_frame[9 - i];
    end

    assign frame_ok = !rx_frame[10] && rx_frame[0] && (^{rx_byte, rx_frame[1]});
    assign rx_good  = rx_done && frame_ok;
    assign rx_bad   = rx_err || (rx_done && !frame_ok);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign expire   = !rx_done && (timer_q == TIMEOUT_CYC - 1);

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        idx_d       = idx_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        tx_byte_d   = tx_byte_q;
        tx_start_d  = 1'b0;
        pkt_valid_d = 1'b0;
        pkt_btn_d   = pkt_btn_q;
        pkt_dx_d    = pkt_dx_q;
        pkt_dy_d    = pkt_dy_q;
        pkt_ovf_d   = pkt_ovf_q;
        enter       = 1'b0;
        init_fail   = 1'b0;
        exp_byte    = 8'hFA;
        wait_next   = StWaitBat;

        case (state_q)
            StWaitBat:  begin exp_byte = 8'hAA; wait_next = StWaitId; end
            StWaitId:   begin exp_byte = 8'h00; wait_next = StSendEn; end
            StWaitAck2: begin exp_byte = 8'hFA; wait_next = StStream; end
            default:    ;
        endcase

        if (!enable && state_q != StFail) begin
            state_d = StIdle;
            enter   = (state_q != StIdle);
            retry_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StSendRst;
                    enter   = 1'b1;
                end
                StSendRst, StSendEn: begin
                    if (tx_err || rx_bad || rx_good || expire) begin
                        init_fail = 1'b1;
                    end else if (tx_done) begin
                        state_d = (state_q == StSendRst) ? StWaitAck1 : StWaitAck2;
                        enter   = 1'b1;
                    end
                end
                StWaitAck1, StWaitBat, StWaitId, StWaitAck2: begin
                    if (rx_bad || expire || (rx_good && rx_byte != exp_byte)) begin
                        init_fail = 1'b1;
                    end else if (rx_good) begin
                        state_d = wait_next;
                        enter   = 1'b1;
                    end
                end
                StStream: begin
                    if (rx_bad) begin
                        idx_d = '0;
                    end else if (rx_good) begin
                        if (rx_byte == 8'hAA) begin
                            state_d = StWaitId;
                            enter   = 1'b1;
                        end else begin
                            case (idx_q)
                                2'd0: if (rx_byte[3]) begin
                                    byte0_d = rx_byte;
                                    idx_d   = 2'd1;
                                end
                                2'd1: begin
                                    byte1_d = rx_byte;
                                    idx_d   = 2'd2;
                                end
                                default: begin
                                    pkt_valid_d = 1'b1;
                                    pkt_btn_d   = byte0_q[2:0];
                                    pkt_dx_d    = {byte0_q[4], byte1_q};
                                    pkt_dy_d    = {byte0_q[5], rx_byte};
                                    pkt_ovf_d   = byte0_q[7:6];
                                    idx_d       = 2'd0;
                                end
                            endcase
                        end
                    end else if (expire) begin
                        idx_d = '0;
                    end
                end
                default: ;
            endcase

            if (init_fail) begin
                enter = 1'b1;
                if (retry_q == RetryW'(MAX_RETRY - 1)) begin
                    state_d = StFail;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = StSendRst;
                end
            end
        end

        if (state_d != StStream) idx_d = '0;

        if (enter && state_d == StSendRst) begin
            tx_start_d = 1'b1;
            tx_byte_d  = 8'hFF;
        end else if (enter && state_d == StSendEn) begin
            tx_start_d = 1'b1;
            tx_byte_d  = 8'hF4;
        end

        timer_d = (enter || rx_done || expire) ? '0 : timer_q + 32'd1;
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            retry_q     <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_btn_q   <= '0;
            pkt_dx_q    <= '0;
            pkt_dy_q    <= '0;
            pkt_ovf_q   <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            tx_byte_q   <= tx_byte_d;
            tx_start_q  <= tx_start_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_btn_q   <= pkt_btn_d;
            pkt_dx_q    <= pkt_dx_d;
            pkt_dy_q    <= pkt_dy_d;
            pkt_ovf_q   <= pkt_ovf_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_start  = tx_start_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_btn   = pkt_btn_q;
    assign pkt_dx    = pkt_dx_q;
    assign pkt_dy    = pkt_dy_q;
    assign pkt_ovf   = pkt_ovf_q;
    assign ready     = (state_q == StStream);
    assign fail      = (state_q == StFail);

endmodule

// File: tb/tb_ps2_mouse_host_ctrl.sv
// Scoreboard bench for ps2_mouse_host_ctrl: expected tx bytes and packets are queued as
// stimulus is driven and popped when the DUT emits tx_start or pkt_valid.
module tb_ps2_mouse_host_ctrl;

    localparam int unsigned TOUT = 300;

    logic        qzt_clk, reset, enable;
    logic [10:0] rx_frame;
    logic        rx_done, rx_err, tx_done, tx_err;
    logic [7:0]  tx_byte;
    logic        tx_start, pkt_valid, ready, fail;
    logic [2:0]  pkt_btn;
    logic [8:0]  pkt_dx, pkt_dy;
    logic [1:0]  pkt_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int tx_cnt   = 0;
    int pkt_cnt  = 0;
    int c0;

    logic [7:0]  exp_tx[$];
    logic [22:0] exp_pkt[$];

    ps2_mouse_host_ctrl #(.TIMEOUT_CYC(TOUT), .MAX_RETRY(3)) dut (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .enable   (enable),
        .rx_frame (rx_frame),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .pkt_valid(pkt_valid),
        .pkt_btn  (pkt_btn),
        .pkt_dx   (pkt_dx),
        .pkt_dy   (pkt_dy),
        .pkt_ovf  (pkt_ovf),
        .ready    (ready),
        .fail     (fail)
    );

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge qzt_clk) begin
        if (tx_start === 1'b1) begin
            tx_cnt++;
            if (exp_tx.size() == 0) check("tx_start_unexpected", 32'(tx_start), 32'd0);
            else check("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
        end
        if (pkt_valid === 1'b1) begin
            pkt_cnt++;
            if (exp_pkt.size() == 0) check("pkt_unexpected", 32'(pkt_valid), 32'd0);
            else check("pkt", 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 32'(exp_pkt.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge qzt_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9 - i] = b[i];
        f[1] = ~(^b) ^ bad_par;
        f[0] = 1'b1;
        rx_frame = f;
        rx_done  = 1'b1;
        step(1);
        rx_done  = 1'b0;
        rx_frame = '0;
        step(2);
    endtask

    // Waits (bounded) for the tx_start counted after c0, then acknowledges it.
    task automatic tx_handshake(input int start_cnt, input logic [7:0] exp, input int budget);
        int i = 0;
        while (tx_cnt == start_cnt && i < budget) begin
            step(1);
            i++;
        end
        if (tx_cnt == start_cnt) begin
            check("tx_start_timeout", 32'(tx_cnt), 32'(start_cnt + 1));
        end else begin
            step(3);
            check("tx_hold", 32'(tx_byte), 32'(exp));
            tx_done = 1'b1;
            step(1);
            tx_done = 1'b0;
        end
    endtask

    task automatic do_init();
        int c;
        c = tx_cnt;
        exp_tx.push_back(8'hFF);
        enable = 1'b1;
        tx_handshake(c, 8'hFF, 50);
        send_frame(8'hFA, 1'b0);
        send_frame(8'hAA, 1'b0);
        c = tx_cnt;
        exp_tx.push_back(8'hF4);
        send_frame(8'h00, 1'b0);
        tx_handshake(c, 8'hF4, 50);
        send_frame(8'hFA, 1'b0);
        step(1);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0);
        send_frame(b1, 1'b0);
        send_frame(b2, 1'b0);
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; rx_frame = '0; rx_done = 1'b0; rx_err = 1'b0;
        tx_done = 1'b0; tx_err = 1'b0;
        step(3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_pkt", 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        reset = 1'b0;
        step(5);
        check("idle_no_tx", 32'(tx_cnt), 32'd0);

        // Nominal init
        do_init();
        check("init_tx_count", 32'(tx_cnt), 32'd2);
        check("init_ready", 32'(ready), 32'd1);
        check("init_fail", 32'(fail), 32'd0);

        // Basic packet
        exp_pkt.push_back({3'b001, 9'h005, 9'h0FB, 2'b00});
        send_packet(8'h09, 8'h05, 8'hFB);
        check("pkt2_count", 32'(pkt_cnt), 32'd1);
        step(10);
        check("pkt2_hold_dx", 32'(pkt_dx), 32'h005);

        // Resync: 0x00 lacks bit3 and is dropped
        exp_pkt.push_back({3'b000, 9'h010, 9'h020, 2'b00});
        send_frame(8'h00, 1'b0);
        send_packet(8'h08, 8'h10, 8'h20);
        check("pkt3_count", 32'(pkt_cnt), 32'd2);

        // Sign and overflow bits
        exp_pkt.push_back({3'b000, 9'h1FF, 9'h180, 2'b11});
        send_packet(8'hF8, 8'hFF, 8'h80);
        check("pkt_ovf_count", 32'(pkt_cnt), 32'd3);

        // Parity error on byte 1 drops the partial packet
        exp_pkt.push_back({3'b010, 9'h007, 9'h003, 2'b00});
        send_frame(8'h09, 1'b0);
        send_frame(8'h05, 1'b1);
        send_packet(8'h0A, 8'h07, 8'h03);
        check("pkt5_count", 32'(pkt_cnt), 32'd4);
        check("pkt5_ready", 32'(ready), 32'd1);
        check("pkt5_fail", 32'(fail), 32'd0);

        // Hot-replug: 0xAA in stream returns to waiting for the ID byte
        send_frame(8'hAA, 1'b0);
        check("replug_ready", 32'(ready), 32'd0);
        c0 = tx_cnt;
        exp_tx.push_back(8'hF4);
        send_frame(8'h00, 1'b0);
        tx_handshake(c0, 8'hF4, 50);
        send_frame(8'hFA, 1'b0);
        check("replug_ready_again", 32'(ready), 32'd1);
        check("replug_no_pkt", 32'(pkt_cnt), 32'd4);

        // Enable low: idle, packet outputs hold
        enable = 1'b0;
        step(2);
        check("dis_ready", 32'(ready), 32'd0);
        check("dis_pkt_hold", 32'(pkt_btn), 32'b010);

        // Reset mid-init in WAIT_BAT
        c0 = tx_cnt;
        exp_tx.push_back(8'hFF);
        enable = 1'b1;
        tx_handshake(c0, 8'hFF, 50);
        send_frame(8'hFA, 1'b0);
        reset = 1'b1;
        step(1);
        check("mid_rst_pkt", 32'({pkt_btn, pkt_dx, pkt_dy, pkt_ovf}), 32'd0);
        check("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_fail", 32'(fail), 32'd0);

        // Restart at FF, then the device stays silent: three attempts, then fail
        c0 = tx_cnt;
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(8'hFF);
            if (k == 0) reset = 1'b0;
            tx_handshake(c0 + k, 8'hFF, 2 * TOUT + 50);
        end
        check("tout_three_tx", 32'(tx_cnt - c0), 32'd3);
        step(TOUT - 20);
        check("tout_fail_early", 32'(fail), 32'd0);
        step(40);
        check("tout_fail", 32'(fail), 32'd1);
        step(TOUT + 20);
        check("tout_no_4th_tx", 32'(tx_cnt - c0), 32'd3);
        enable = 1'b0;
        step(3);
        check("fail_sticky", 32'(fail), 32'd1);
        reset = 1'b1;
        step(1);
        check("fail_cleared", 32'(fail), 32'd0);
        reset = 1'b0;
        step(2);

        check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        check("pkt_queue_empty", 32'(exp_pkt.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
